// File: rtl/cg_img_proc.sv
`default_nettype none
//==============================================================================
// Module      : cg_img_proc
// Description : 8x8 signed image / op-stream window processor. Buffers 64
//               7-bit signed pixels and 15 opcodes. It runs the opcodes in
//               order on a movable 4x4 window, then streams the 16 window
//               pixels out in raster order.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               cg_en     - clock-gating enable (used only with CG_CLK_GATE_EN)
//               in_valid  - pixel/op input strobe (64 consecutive cycles)
//               in_data   - signed pixel, raster order 0..63
//               op        - opcode, valid during the first 15 input cycles
//               out_valid - output strobe (16 consecutive cycles)
//               out_data  - signed window pixel, 0 when out_valid is low
// Config      : `define CG_CLK_GATE_EN gives the image bank, the op buffer and
//               the output register latch-based clock gates.
// Revision    : 1.0 - initial release
//==============================================================================
module cg_img_proc (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cg_en,
    input  logic              in_valid,
    input  logic signed [6:0] in_data,
    input  logic        [3:0] op,
    output logic              out_valid,
    output logic signed [6:0] out_data
);

    localparam logic        [5:0] C_LAST_PIX = 6'd63;
    localparam logic        [5:0] C_LAST_OP  = 6'd14;
    localparam logic        [5:0] C_LAST_OUT = 6'd15;
    localparam logic        [5:0] C_NUM_OPS  = 6'd15;
    localparam logic        [2:0] C_ORG_INIT = 3'd2;
    localparam logic        [2:0] C_ORG_MAX  = 3'd4;
    localparam logic signed [6:0] C_PIX_MAX  = 7'sb011_1111;
    localparam logic signed [6:0] C_PIX_MIN  = 7'sb100_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic        [5:0] r_cnt;
    logic        [2:0] r_orow;
    logic        [2:0] r_ocol;
    logic signed [6:0] r_img [64];
    logic        [3:0] r_ops [16];

    logic              w_img_ld;
    logic              w_op_ld;
    logic              w_exec_wr;
    logic              w_img_wr;
    logic              w_out_wr;
    logic        [3:0] w_cur_op;
    logic        [5:0] w_win_idx [16];
    logic signed [6:0] w_win     [16];
    logic signed [6:0] w_res     [16];
    logic signed [6:0] w_img_nxt [64];
    logic        [2:0] w_gclk;   // [0] image bank, [1] op buffer, [2] output

    function automatic logic signed [6:0] f_neg_sat(input logic signed [6:0] v);
        return (v == C_PIX_MIN) ? C_PIX_MAX : -v;
    endfunction

    function automatic logic signed [6:0] f_inc_sat(input logic signed [6:0] v);
        return (v == C_PIX_MAX) ? C_PIX_MAX : v + 7'sd1;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_cnt is 0 whenever the FSM sits in IDLE, so it doubles as the load index.
    always_comb begin
        w_state_nxt = r_state;
        w_img_ld    = 1'b0;
        w_exec_wr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_img_ld = in_valid;
                if (in_valid) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_img_ld = in_valid;
                if (in_valid && r_cnt == C_LAST_PIX) w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_exec_wr = (w_cur_op[3:2] == 2'b01);   // ops 4..7 edit pixels
                if (r_cnt == C_LAST_OP) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (r_cnt == C_LAST_OUT) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_op_ld  = w_img_ld && (r_cnt < C_NUM_OPS);
    assign w_img_wr = w_img_ld | w_exec_wr;
    assign w_out_wr = (r_state == S_OUT) | out_valid;  // also clears after OUT
    assign w_cur_op = r_ops[r_cnt[3:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE:  r_cnt <= in_valid ? 6'd1 : 6'd0;
                S_LOAD:  if (in_valid) r_cnt <= (r_cnt == C_LAST_PIX) ? 6'd0 : r_cnt + 6'd1;
                S_EXEC:  r_cnt <= (r_cnt == C_LAST_OP)  ? 6'd0 : r_cnt + 6'd1;
                S_OUT:   r_cnt <= (r_cnt == C_LAST_OUT) ? 6'd0 : r_cnt + 6'd1;
                default: r_cnt <= 6'd0;
            endcase
        end
    end

    // ------------------------------------------------------- window origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_orow <= C_ORG_INIT;
            r_ocol <= C_ORG_INIT;
        end else if (r_state == S_LOAD && in_valid && r_cnt == C_LAST_PIX) begin
            r_orow <= C_ORG_INIT;
            r_ocol <= C_ORG_INIT;
        end else if (r_state == S_EXEC) begin
            case (w_cur_op)
                4'd0:    if (r_orow != 3'd0)    r_orow <= r_orow - 3'd1;
                4'd1:    if (r_orow != C_ORG_MAX) r_orow <= r_orow + 3'd1;
                4'd2:    if (r_ocol != 3'd0)    r_ocol <= r_ocol - 3'd1;
                4'd3:    if (r_ocol != C_ORG_MAX) r_ocol <= r_ocol + 3'd1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------- window read / edit / merge
    // The origin never exceeds 4, so row and column each fit in 3 bits and
    // the flat image index is simply {row, col}.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_win_idx[i] = {r_orow + 3'(i / 4), r_ocol + 3'(i % 4)};
            w_win[i]     = r_img[w_win_idx[i]];
        end
        for (int i = 0; i < 16; i++) begin
            w_res[i] = w_win[i];
            case (w_cur_op)
                4'd4:    w_res[i] = f_neg_sat(w_win[i]);
                4'd5:    w_res[i] = w_win[(i % 4) * 4 + i / 4];
                4'd6:    w_res[i] = w_win[(i / 4) * 4 + 3 - (i % 4)];
                4'd7:    w_res[i] = f_inc_sat(w_win[i]);
                default: ;
            endcase
        end
        w_img_nxt = r_img;
        for (int i = 0; i < 16; i++) begin
            w_img_nxt[w_win_idx[i]] = w_res[i];
        end
    end

    // ---------------------------------------------------------- clock gates
`ifdef CG_CLK_GATE_EN
    logic [2:0] w_gate_en;
    assign w_gate_en = {w_out_wr, w_op_ld, w_img_wr} | {3{~cg_en}};

    // Enable is captured while clk is low so the gated clock never glitches.
    for (genvar g = 0; g < 3; g++) begin : g_cg
        logic r_lat;
        always_latch begin
            if (!clk) r_lat <= w_gate_en[g];
        end
        assign w_gclk[g] = clk & r_lat;
    end
`else
    logic w_unused_cg;
    assign w_unused_cg = cg_en;
    assign w_gclk      = {3{clk}};
`endif

    // ---------------------------------------------------------- data banks
    always_ff @(posedge w_gclk[0]) begin
        if (w_img_ld)       r_img[r_cnt] <= in_data;
        else if (w_exec_wr) r_img        <= w_img_nxt;
    end

    always_ff @(posedge w_gclk[1]) begin
        if (w_op_ld) r_ops[r_cnt[3:0]] <= op;
    end

    always_ff @(posedge w_gclk[2] or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (w_out_wr) begin
            out_valid <= (r_state == S_OUT);
            out_data  <= (r_state == S_OUT) ? w_win[r_cnt[3:0]] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cg_img_proc.sv
`default_nettype none
//==============================================================================
// Module      : tb_cg_img_proc
// Description : Self-checking bench for cg_img_proc: directed scenarios with
//               constant expectations plus randomized back-to-back patterns
//               checked against a 2-D array reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_cg_img_proc;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cg_en;
    logic              in_valid;
    logic signed [6:0] in_data;
    logic        [3:0] op;
    logic              out_valid;
    logic signed [6:0] out_data;

    int checks = 0;
    int errors = 0;

    logic signed [6:0] g_pix [64];
    logic        [3:0] g_ops [15];
    logic signed [6:0] g_exp [16];
    logic signed [6:0] g_got [16];
    int                g_n_out;
    int                g_first;
    int                g_zero_bad;
    int                g_contig_bad;
    bit                g_timeout;

    int c_ramp_exp [16] = '{-14, -13, -12, -11, -6, -5, -4, -3, 2, 3, 4, 5, 10, 11, 12, 13};
    int c_org_exp  [16] = '{-32, -31, -30, -29, -24, -23, -22, -21, -16, -15, -14, -13, -8, -7, -6, -5};
    int c_tr_exp   [16] = '{-14, -6, 2, 10, -13, -5, 3, 11, -12, -4, 4, 12, -11, -3, 5, 13};

    cg_img_proc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cg_en     (cg_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ reference model
    function automatic int sat7(input int v);
        if (v > 63)  return 63;
        if (v < -64) return -64;
        return v;
    endfunction

    task automatic compute_model();
        int img [8][8];
        int w   [4][4];
        int orow = 2;
        int ocol = 2;
        for (int k = 0; k < 64; k++) img[k / 8][k % 8] = int'(g_pix[k]);
        for (int j = 0; j < 15; j++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) w[r][c] = img[orow + r][ocol + c];
            case (g_ops[j])
                4'd0: orow = (orow > 0) ? orow - 1 : 0;
                4'd1: orow = (orow < 4) ? orow + 1 : 4;
                4'd2: ocol = (ocol > 0) ? ocol - 1 : 0;
                4'd3: ocol = (ocol < 4) ? ocol + 1 : 4;
                4'd4: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
                          img[orow + r][ocol + c] = sat7(-w[r][c]);
                4'd5: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
                          img[orow + r][ocol + c] = w[c][r];
                4'd6: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
                          img[orow + r][ocol + c] = w[r][3 - c];
                4'd7: for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
                          img[orow + r][ocol + c] = sat7(w[r][c] + 1);
                default: ;
            endcase
        end
        for (int i = 0; i < 16; i++) g_exp[i] = 7'(img[orow + i / 4][ocol + i % 4]);
    endtask

    // ---------------------------------------------------- stimulus helpers
    task automatic drive_pixels(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = g_pix[k];
            op       = (k < 15) ? g_ops[k] : 4'($urandom);
        end
    endtask

    // Drives a full pattern and records the output stream. Negedge n counts
    // from the first negedge after the last pixel is sampled. With junk set,
    // in_valid is toggled only while the DUT is in EXEC/OUT.
    task automatic drive_capture(input bit junk);
        drive_pixels(64);
        g_n_out = 0; g_first = -1; g_zero_bad = 0; g_contig_bad = 0; g_timeout = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (g_first < 0) g_first = n;
                if (g_n_out < 16) g_got[g_n_out] = out_data;
                g_n_out++;
                if (n != g_first + g_n_out - 1) g_contig_bad++;
            end else begin
                if (out_data !== 7'sd0) g_zero_bad++;
                if (g_n_out > 0) begin
                    g_timeout = 1'b0;
                    break;
                end
            end
            if (junk && n <= 31) begin
                in_valid = 1'($urandom);
                in_data  = 7'($urandom);
                op       = 4'($urandom);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
        end
    endtask

    task automatic set_ramp_noop();
        for (int k = 0; k < 64; k++) g_pix[k] = 7'(k - 32);
        for (int j = 0; j < 15; j++) g_ops[j] = 4'd15;
    endtask

    // ----------------------------------------------------------- scenarios
    task automatic test_reset();
        rst_n = 1'b0; cg_en = 1'b1; in_valid = 1'b0; in_data = '0; op = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 7'sd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b out_data=%0d, required 0/0", out_valid, out_data);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 7'sd0) begin
            errors++;
            $display("FAIL idle_after_reset: out_valid=%b out_data=%0d, required 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_noop_default(input string name);
        set_ramp_noop();
        drive_capture(1'b0);
        checks++;
        if (g_timeout !== 1'b0 || g_n_out !== 16 || g_contig_bad !== 0) begin
            errors++;
            $display("FAIL %s_stream: outputs=%0d gaps=%0d timeout=%b, required 16/0/0", name, g_n_out, g_contig_bad, g_timeout);
        end
        checks++;
        if (g_first !== 17) begin
            errors++;
            $display("FAIL %s_latency: first output %0d cycles after last pixel, required 16", name, g_first - 1);
        end
        checks++;
        if (g_zero_bad !== 0) begin
            errors++;
            $display("FAIL %s_idle_zero: %0d nonzero idle samples, required 0", name, g_zero_bad);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (g_got[i] !== 7'(c_ramp_exp[i])) begin
                errors++;
                $display("FAIL %s_pix[%0d]: got %0d, required %0d", name, i, g_got[i], c_ramp_exp[i]);
            end
        end
    endtask

    task automatic test_origin_sat();
        set_ramp_noop();
        g_ops[0] = 4'd0; g_ops[1] = 4'd0; g_ops[2] = 4'd0;
        g_ops[3] = 4'd2; g_ops[4] = 4'd2; g_ops[5] = 4'd2;
        drive_capture(1'b0);
        checks++;
        if (g_timeout !== 1'b0 || g_n_out !== 16) begin
            errors++;
            $display("FAIL origin_sat_stream: outputs=%0d timeout=%b, required 16/0", g_n_out, g_timeout);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (g_got[i] !== 7'(c_org_exp[i])) begin
                errors++;
                $display("FAIL origin_sat_pix[%0d]: got %0d, required %0d", i, g_got[i], c_org_exp[i]);
            end
        end
    endtask

    task automatic test_value_sat();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 64; k++) g_pix[k] = (s == 0) ? 7'sd63 : 7'sb100_0000;
            for (int j = 0; j < 15; j++) g_ops[j] = 4'd15;
            if (s == 0) begin g_ops[0] = 4'd7; g_ops[1] = 4'd4; end
            else        g_ops[0] = 4'd4;
            drive_capture(1'b0);
            checks++;
            if (g_timeout !== 1'b0 || g_n_out !== 16) begin
                errors++;
                $display("FAIL value_sat%0d_stream: outputs=%0d timeout=%b, required 16/0", s, g_n_out, g_timeout);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (g_got[i] !== ((s == 0) ? -7'sd63 : 7'sd63)) begin
                    errors++;
                    $display("FAIL value_sat%0d_pix[%0d]: got %0d, required %0d", s, i, g_got[i], (s == 0) ? -63 : 63);
                end
            end
        end
    endtask

    task automatic test_transpose();
        set_ramp_noop();
        g_ops[0] = 4'd5;
        drive_capture(1'b0);
        checks++;
        if (g_timeout !== 1'b0 || g_n_out !== 16) begin
            errors++;
            $display("FAIL transpose_stream: outputs=%0d timeout=%b, required 16/0", g_n_out, g_timeout);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (g_got[i] !== 7'(c_tr_exp[i])) begin
                errors++;
                $display("FAIL transpose_pix[%0d]: got %0d, required %0d", i, g_got[i], c_tr_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        set_ramp_noop();
        drive_pixels(31);
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 7'sd0) begin
                errors++;
                $display("FAIL reset_mid_load: out_valid=%b out_data=%0d, required 0/0", out_valid, out_data);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_noop_default("after_reset_load");
    endtask

    task automatic test_reset_mid_out();
        bit seen = 1'b0;
        set_ramp_noop();
        drive_pixels(64);
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            seen = (out_valid === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid_out_wait: out_valid=%b, required 1 within 40 cycles", out_valid);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 7'sd0) begin
            errors++;
            $display("FAIL reset_mid_out_async: out_valid=%b out_data=%0d, required 0/0", out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 7'sd0) begin
            errors++;
            $display("FAIL reset_mid_out_after: out_valid=%b out_data=%0d, required 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back(input int n_pat);
        for (int p = 0; p < n_pat; p++) begin
            cg_en = 1'($urandom);
            for (int k = 0; k < 64; k++) begin
                case ($urandom % 8)
                    0:       g_pix[k] = 7'sd63;
                    1:       g_pix[k] = 7'sb100_0000;
                    default: g_pix[k] = 7'($urandom);
                endcase
            end
            for (int j = 0; j < 15; j++)
                g_ops[j] = ($urandom % 3 == 0) ? 4'($urandom) : 4'($urandom % 8);
            compute_model();
            drive_capture(($urandom % 4) == 0);
            checks++;
            if (g_timeout !== 1'b0 || g_n_out !== 16 || g_first !== 17 ||
                g_zero_bad !== 0 || g_contig_bad !== 0) begin
                errors++;
                $display("FAIL rand%0d_stream: outputs=%0d first=%0d zero_bad=%0d gaps=%0d timeout=%b, required 16/17/0/0/0",
                         p, g_n_out, g_first, g_zero_bad, g_contig_bad, g_timeout);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (g_got[i] !== g_exp[i]) begin
                    errors++;
                    $display("FAIL rand%0d_pix[%0d]: got %0d, required %0d", p, i, g_got[i], g_exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_noop_default("noop_default");
        test_origin_sat();
        test_value_sat();
        test_transpose();
        test_reset_mid_load();
        test_reset_mid_out();
        cg_en = 1'b0;
        test_noop_default("noop_cg_off");
        test_back_to_back(300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
